// File: rtl/rf_rename_mp_pkg.sv
// Shared constants for the multi-port renaming register file.
// Optional checkpointing is enabled with the RF_CHECKPOINT_EN macro.
package rf_rename_mp_pkg;
    localparam int RF_REG_NUM_WIDTH  = 5;
    localparam int RF_REG_NUM        = 2 ** RF_REG_NUM_WIDTH;
    localparam int RF_ROB_SIZE_WIDTH = 4;
    localparam logic [RF_ROB_SIZE_WIDTH-1:0] RF_NO_DEP = '1;
    localparam int RF_DATA_W         = 32;
    localparam int RF_NUM_READ       = 3;
    localparam int RF_COMMIT_W       = 2;
    localparam int RF_DISPATCH_W     = 2;
endpackage

// File: rtl/rf_rename_mp_read_bypass.sv
// One read port: value from the youngest commit or the array, tag from the
// youngest dispatch, a matching commit (cleared), or the rename table.
module rf_read_bypass
    import rf_rename_mp_pkg::*;
#(
    parameter int REG_NUM_WIDTH  = RF_REG_NUM_WIDTH,
    parameter int ROB_SIZE_WIDTH = RF_ROB_SIZE_WIDTH,
    parameter int COMMIT_W       = RF_COMMIT_W,
    parameter int DISPATCH_W     = RF_DISPATCH_W
) (
    input  logic [REG_NUM_WIDTH-1:0]             idx,
    input  logic [31:0]                          reg_value,
    input  logic [ROB_SIZE_WIDTH-1:0]            reg_tag,
    input  logic [COMMIT_W-1:0]                  rob_valid,
    input  logic [COMMIT_W*REG_NUM_WIDTH-1:0]    rob_rd,
    input  logic [COMMIT_W*32-1:0]               rob_value,
    input  logic [COMMIT_W*ROB_SIZE_WIDTH-1:0]   rob_dependency,
    input  logic [DISPATCH_W-1:0]                dec_valid,
    input  logic [DISPATCH_W*REG_NUM_WIDTH-1:0]  dec_rd,
    input  logic [DISPATCH_W*ROB_SIZE_WIDTH-1:0] dec_dependency,
    output logic [31:0]                          value_out,
    output logic [ROB_SIZE_WIDTH-1:0]            tag_out
);
    localparam logic [ROB_SIZE_WIDTH-1:0] NO_DEP = '1;

    logic commit_clears;

    always_comb begin
        value_out     = reg_value;
        tag_out       = reg_tag;
        commit_clears = 1'b0;
        // Ascending loops so the highest-index matching port wins.
        for (int c = 0; c < COMMIT_W; c++) begin
            if (rob_valid[c] && rob_rd[c*REG_NUM_WIDTH +: REG_NUM_WIDTH] == idx) begin
                value_out = rob_value[c*32 +: 32];
                if (rob_dependency[c*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH] == reg_tag) begin
                    commit_clears = 1'b1;
                end
            end
        end
        if (commit_clears) begin
            tag_out = NO_DEP;
        end
        for (int d = 0; d < DISPATCH_W; d++) begin
            if (dec_valid[d] && dec_rd[d*REG_NUM_WIDTH +: REG_NUM_WIDTH] == idx) begin
                tag_out = dec_dependency[d*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH];
            end
        end
        if (idx == '0) begin
            value_out = '0;
            tag_out   = NO_DEP;
        end
    end
endmodule

// File: rtl/rf_rename_mp.sv
// Multi-port architectural register file with ROB rename tags and flush recovery.
// Define RF_CHECKPOINT_EN to add a shadow tag table with save/restore ports.
module rf_rename_mp
    import rf_rename_mp_pkg::*;
#(
    parameter int REG_NUM_WIDTH  = RF_REG_NUM_WIDTH,
    parameter int ROB_SIZE_WIDTH = RF_ROB_SIZE_WIDTH,
    parameter int NUM_READ       = RF_NUM_READ,
    parameter int COMMIT_W       = RF_COMMIT_W,
    parameter int DISPATCH_W     = RF_DISPATCH_W
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 rdy_in,
    input  logic                                 need_flush_in,
`ifdef RF_CHECKPOINT_EN
    input  logic                                 ckpt_save,
    input  logic                                 ckpt_restore,
`endif
    input  logic [COMMIT_W-1:0]                  rob_valid,
    input  logic [COMMIT_W*REG_NUM_WIDTH-1:0]    rob_rd,
    input  logic [COMMIT_W*32-1:0]               rob_value,
    input  logic [COMMIT_W*ROB_SIZE_WIDTH-1:0]   rob_dependency,
    input  logic [DISPATCH_W-1:0]                dec_valid,
    input  logic [DISPATCH_W*REG_NUM_WIDTH-1:0]  dec_rd,
    input  logic [DISPATCH_W*ROB_SIZE_WIDTH-1:0] dec_dependency,
    input  logic [NUM_READ*REG_NUM_WIDTH-1:0]    rd_idx,
    output logic [NUM_READ*32-1:0]               rd_value_out,
    output logic [NUM_READ*ROB_SIZE_WIDTH-1:0]   rd_dependency_out
);
    localparam int REG_NUM = 2 ** REG_NUM_WIDTH;
    localparam logic [ROB_SIZE_WIDTH-1:0] NO_DEP = '1;

    typedef logic [31:0]               word_t;
    typedef logic [ROB_SIZE_WIDTH-1:0] tag_t;
    typedef logic [REG_NUM_WIDTH-1:0]  idx_t;

    word_t regs_q  [REG_NUM];
    word_t regs_d  [REG_NUM];
    tag_t  table_q [REG_NUM];
    tag_t  table_d [REG_NUM];
`ifdef RF_CHECKPOINT_EN
    tag_t  shadow_q   [REG_NUM];
    tag_t  shadow_d   [REG_NUM];
    tag_t  shadow_clr [REG_NUM];
`endif

    idx_t  commit_rd  [COMMIT_W];
    word_t commit_val [COMMIT_W];
    tag_t  commit_tag [COMMIT_W];
    idx_t  disp_rd    [DISPATCH_W];
    tag_t  disp_tag   [DISPATCH_W];

    genvar gi;
    generate
        for (gi = 0; gi < COMMIT_W; gi++) begin : g_commit_unpack
            assign commit_rd[gi]  = rob_rd[gi*REG_NUM_WIDTH +: REG_NUM_WIDTH];
            assign commit_val[gi] = rob_value[gi*32 +: 32];
            assign commit_tag[gi] = rob_dependency[gi*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH];
        end
        for (gi = 0; gi < DISPATCH_W; gi++) begin : g_disp_unpack
            assign disp_rd[gi]  = dec_rd[gi*REG_NUM_WIDTH +: REG_NUM_WIDTH];
            assign disp_tag[gi] = dec_dependency[gi*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH];
        end
    endgenerate

    always_comb begin
        regs_d  = regs_q;
        table_d = table_q;
        // Commits retire values; a tag clears only if it is still the youngest producer.
        for (int c = 0; c < COMMIT_W; c++) begin
            if (rob_valid[c] && commit_rd[c] != '0) begin
                regs_d[commit_rd[c]] = commit_val[c];
                if (commit_tag[c] == table_q[commit_rd[c]]) begin
                    table_d[commit_rd[c]] = NO_DEP;
                end
            end
        end
        for (int d = 0; d < DISPATCH_W; d++) begin
            if (dec_valid[d] && disp_rd[d] != '0) begin
                table_d[disp_rd[d]] = disp_tag[d];
            end
        end
        if (need_flush_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                table_d[i] = NO_DEP;
            end
        end
`ifdef RF_CHECKPOINT_EN
        // Retired tags are scrubbed from the shadow so a restore cannot revive them.
        shadow_clr = shadow_q;
        for (int i = 0; i < REG_NUM; i++) begin
            for (int c = 0; c < COMMIT_W; c++) begin
                if (rob_valid[c] && commit_tag[c] == shadow_q[i]) begin
                    shadow_clr[i] = NO_DEP;
                end
            end
        end
        if (ckpt_save && !ckpt_restore) begin
            shadow_d = table_d;
        end else begin
            shadow_d = shadow_clr;
        end
        if (ckpt_restore) begin
            table_d = shadow_clr;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i]   <= '0;
                table_q[i]  <= NO_DEP;
`ifdef RF_CHECKPOINT_EN
                shadow_q[i] <= NO_DEP;
`endif
            end
        end else if (rdy_in) begin
            regs_q   <= regs_d;
            table_q  <= table_d;
`ifdef RF_CHECKPOINT_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_read
            idx_t port_idx;
            assign port_idx = rd_idx[gi*REG_NUM_WIDTH +: REG_NUM_WIDTH];

            rf_read_bypass #(
                .REG_NUM_WIDTH  (REG_NUM_WIDTH),
                .ROB_SIZE_WIDTH (ROB_SIZE_WIDTH),
                .COMMIT_W       (COMMIT_W),
                .DISPATCH_W     (DISPATCH_W)
            ) u_bypass (
                .idx            (port_idx),
                .reg_value      (regs_q[port_idx]),
                .reg_tag        (table_q[port_idx]),
                .rob_valid      (rob_valid),
                .rob_rd         (rob_rd),
                .rob_value      (rob_value),
                .rob_dependency (rob_dependency),
                .dec_valid      (dec_valid),
                .dec_rd         (dec_rd),
                .dec_dependency (dec_dependency),
                .value_out      (rd_value_out[gi*32 +: 32]),
                .tag_out        (rd_dependency_out[gi*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH])
            );
        end
    endgenerate
endmodule

// File: doc/rf_rename_mp.md
Name: rf_rename_mp

Overview:
- Parametrised multi-port architectural register file with per-register rename tags (ROB index of the youngest in-flight producer).
- Sits between decode/dispatch and the ROB: serves operand values and dependency tags to decode/IF, accepts several commits and several dispatches per cycle, and recovers on flush.
- Successor of the single-port register file. Adds configurable commit/dispatch/read widths, a correct per-operand commit bypass, and optional branch checkpointing.

Parameters:
- REG_NUM_WIDTH, 5, register index width; REG_NUM = 2**REG_NUM_WIDTH.
- ROB_SIZE_WIDTH, 4, tag width; all-ones tag (NO_DEP) means "no dependency", so usable ROB tags are 0..2**ROB_SIZE_WIDTH-2.
- NUM_READ, 3, number of combinational read ports.
- COMMIT_W, 2, ROB commit ports per cycle.
- DISPATCH_W, 2, rename (dispatch) ports per cycle.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous reset, active-high
- rdy_in  in  1  global ready; low freezes all state
- need_flush_in  in  1  mispredict/exception flush
- rob_valid  in  COMMIT_W  per-port commit valid
- rob_rd  in  COMMIT_W*REG_NUM_WIDTH  commit destinations
- rob_value  in  COMMIT_W*32  commit values
- rob_dependency  in  COMMIT_W*ROB_SIZE_WIDTH  committing ROB tags
- dec_valid  in  DISPATCH_W  per-slot dispatch-with-rd valid
- dec_rd  in  DISPATCH_W*REG_NUM_WIDTH  dispatch destinations
- dec_dependency  in  DISPATCH_W*ROB_SIZE_WIDTH  allocated ROB tags
- rd_idx  in  NUM_READ*REG_NUM_WIDTH  read indices
- rd_value_out  out  NUM_READ*32  read values
- rd_dependency_out  out  NUM_READ*ROB_SIZE_WIDTH  read tags (NO_DEP if ready)

Behaviour:
- Reset (rst_in high at posedge, regardless of rdy_in):
  - all regs cleared to 0; all tags set to NO_DEP; shadow table (if present) set to NO_DEP.
  - Outputs are combinational; after reset they read 0 / NO_DEP.
- rdy_in low and no reset: no state change; read ports remain valid.
- x0: never written, never tagged. Reads always return value 0 and tag NO_DEP, including when bypass sources target x0.
- Read value, port p:
  - highest-index commit port c with rob_valid[c] and rob_rd[c]==rd_idx[p] supplies rob_value[c];
  - otherwise regs[rd_idx[p]].
- Read tag, port p, in priority order:
  - highest-index dispatch slot d with dec_valid[d] and dec_rd[d]==rd_idx[p] supplies dec_dependency[d];
  - else NO_DEP if any valid commit c has rob_rd[c]==rd_idx[p] and rob_dependency[c]==table[rd_idx[p]];
  - else table[rd_idx[p]].
  - Each port compares against its own index.
- Clock edge, rdy_in high, no flush:
  - each valid commit with rd!=0 writes regs[rd]; for the same rd, the highest commit index wins;
  - table[rd] becomes NO_DEP if any commit tag equals the stored tag;
  - dispatch then sets table[dec_rd[d]]=dec_dependency[d]; dispatch overrides a commit clear; for the same rd, the highest slot wins.
- Flush cycle:
  - commit writes to regs are still applied (architecturally retired);
  - all tags become NO_DEP; all dispatch inputs are ignored.
- Latency: read-to-output combinational; table/regs updates are visible from the next cycle, and via bypass in the same cycle.

Optional Feature:
- Macro RF_CHECKPOINT_EN. When defined, adds the following ports:
  - ckpt_save (in, 1): shadow <= next-state tag table of this cycle, including this cycle's dispatches.
  - ckpt_restore (in, 1): table <= shadow. Has priority over need_flush_in and over dispatch; commits still write values.
- Shadow maintenance: every cycle, shadow entries whose tag matches a valid commit are cleared to NO_DEP, so a restore never resurrects retired tags.
- Save and restore in the same cycle: restore wins; the shadow keeps its commit-cleared contents.
- When not defined: no shadow, no extra ports, and need_flush_in is the only recovery path.

Decomposition:
- Shared package/header: REG_NUM_WIDTH, REG_NUM, ROB_SIZE_WIDTH, NO_DEP constant, default widths.
- One sub-module, rf_read_bypass: a single read port's value/tag priority mux, instantiated NUM_READ times.

Test Plan:
- Reset, then read x1..x3 -> 0 / NO_DEP; dispatch x1 tag 5, next cycle read x1 -> tag 5.
- Same cycle: commit0 x2=0xAA tag 3 (table x2=3) and commit1 x2=0xBB tag 3 -> read value 0xBB, tag NO_DEP; next cycle regs[x2]=0xBB.
- Commit x4 tag 2 while dispatch slot1 writes x4 tag 6 -> read tag 6 same cycle; table x4=6 afterwards.
- Read port reading x7 (tag 1) while commit x7 tag 1 and a second port reads x8 (tag 1) -> only x7 clears; x8 still 1.
- Flush with commit x9=0x55 and dispatch x10 tag 4 -> regs[x9]=0x55, all tags NO_DEP, x10 untagged; rdy_in low same pattern -> no change.
- RF_CHECKPOINT_EN: save with x1=5; commit tag 5; dispatch x1=7; restore -> x1 NO_DEP.
